// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// IFETCH_BOUNDS_CHECK_EN (optional) uses pc_in_imem() to fault on fetches past IMEM_WORDS.
package ifetch_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned IMEM_WORDS = 1024;
    localparam int unsigned IMEM_BYTES = IMEM_WORDS * WORD_BYTES;
    localparam int unsigned ENTRY_W    = 2 * ADDR_W;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        HALT    = 2'd3
    } ifetch_state_e;

    function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(WORD_BYTES);
    endfunction

    function automatic logic pc_in_imem(input logic [ADDR_W-1:0] pc);
        return pc < ADDR_W'(IMEM_BYTES);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with synchronous flush.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module ifetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fixed-latency imem fetch FSM feeding a prefetch FIFO.
// Define IFETCH_BOUNDS_CHECK_EN to fault when the fetch PC leaves the 1024-word imem.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned       MEM_LATENCY = 2,
    parameter int unsigned       FIFO_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fault
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 1);

    ifetch_state_e     state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              fault_q, fault_d;

    logic               fifo_push, fifo_pop, fifo_flush;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

    assign imem_addr   = fetch_pc_q;
    assign fault       = fault_q;
    assign instr_valid = !fifo_empty;
    assign instr_out   = fifo_empty ? '0 : fifo_rdata[31:0];
    assign instr_pc    = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1:32];
    assign fifo_pop    = instr_valid && instr_ready;
    assign fifo_wdata  = {fetch_pc_q, imem_instr};

    // Redirect is evaluated ahead of the state case so it overrides a capture in the same cycle.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        if (state_q != HALT && redirect_valid) begin
            fifo_flush = 1'b1;
            wait_cnt_d = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = HALT;
            end else begin
                fetch_pc_d = redirect_pc;
                state_d    = ISSUE;
            end
        end else begin
            case (state_q)
                ISSUE: begin
                    wait_cnt_d = '0;
                    state_d    = WAIT;
`ifdef IFETCH_BOUNDS_CHECK_EN
                    if (!pc_in_imem(fetch_pc_q)) begin
                        fault_d    = 1'b1;
                        fifo_flush = 1'b1;
                        state_d    = HALT;
                    end
`endif
                end
                WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = CAPTURE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
                CAPTURE: begin
                    if (!fifo_full || fifo_pop) begin
                        fifo_push  = 1'b1;
                        fetch_pc_d = next_word(fetch_pc_q);
                        state_d    = ISSUE;
                    end
                end
                HALT: begin
                end
                default: begin
                    state_d = ISSUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ISSUE;
            fetch_pc_q <= RESET_PC;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    ifetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
